// File: rtl/lcd_write_engine_if.sv
// Requester/panel-side bundle for lcd_write_engine: byte handshake, status and LCD pins.
// DW must be 4 when the engine runs a 4-bit bus, 8 otherwise.
interface lcd_write_engine_if #(
  parameter int DW = 8
);
  logic [7:0]    iDATA;
  logic          iRS;
  logic          iSingle;
  logic          iValid;
  logic          oReady;
  logic          oDone;
  logic          oBusy;
  logic [DW-1:0] LCD_DATA;
  logic          LCD_RW;
  logic          LCD_EN;
  logic          LCD_RS;
  logic [2:0]    dbg_state;

  // Handshake: a byte transfers on the rising clock edge where iValid && oReady;
  // iDATA/iRS/iSingle are sampled on that edge, iValid while busy is dropped.
  modport slave (
    input  iDATA, iRS, iSingle, iValid,
    output oReady, oDone, oBusy, LCD_DATA, LCD_RW, LCD_EN, LCD_RS, dbg_state
  );

  modport master (
    output iDATA, iRS, iSingle, iValid,
    input  oReady, oDone, oBusy, LCD_DATA, LCD_RW, LCD_EN, LCD_RS, dbg_state
  );
endinterface

// File: rtl/lcd_write_engine.sv
// HD44780-class LCD write engine: one byte per handshake, 8-bit or two-nibble 4-bit bus,
// programmable setup/enable/hold timing and a post-write busy wait (long after clear/home).
module lcd_write_engine #(
  parameter int BUS_4BIT      = 0,
  parameter int SETUP_CYC     = 2,
  parameter int EN_HIGH_CYC   = 12,
  parameter int HOLD_CYC      = 2,
  parameter int CMD_WAIT_CYC  = 2000,
  parameter int LONG_WAIT_CYC = 80000,
  parameter int CNT_W         = 17
) (
  input  logic             iCLK,
  input  logic             reset,
  lcd_write_engine_if.slave bus
);

  localparam int DW = (BUS_4BIT != 0) ? 4 : 8;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = (CMD_WAIT_CYC > 0)  ? CNT_W'(CMD_WAIT_CYC - 1)  : '0;
  localparam logic [CNT_W-1:0] LONG_LAST  = (LONG_WAIT_CYC > 0) ? CNT_W'(LONG_WAIT_CYC - 1) : '0;
  localparam bit               CMD_NONE   = (CMD_WAIT_CYC == 0);
  localparam bit               LONG_NONE  = (LONG_WAIT_CYC == 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EN_HI = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       lo_q;
  logic             single_q;
  logic             long_q;
  logic             second_q;
  logic [DW-1:0]    lcd_data_q;
  logic             lcd_rs_q;
  logic             lcd_en_q;

  logic             accept;
  logic             is_long;
  logic             more_nibble;
  logic             wait_none;
  logic [CNT_W-1:0] wait_last;
  logic             load_second;
  logic [DW-1:0]    first_part;
  logic [DW-1:0]    second_part;

  assign accept  = bus.iValid && (state_q == S_IDLE);
  // Clear (0x01) and return-home (0x02/0x03) need the long busy wait.
  assign is_long = !bus.iRS && (bus.iDATA[7:2] == 6'd0) && (bus.iDATA[1:0] != 2'd0);

  assign more_nibble = (BUS_4BIT != 0) && !second_q && !single_q;
  assign wait_none   = long_q ? LONG_NONE : CMD_NONE;
  assign wait_last   = long_q ? LONG_LAST : CMD_LAST;

  always_comb begin
    first_part  = '0;
    second_part = '0;
    if (BUS_4BIT != 0) begin
      first_part  = DW'(bus.iDATA[7:4]);
      second_part = DW'(lo_q);
    end else begin
      first_part  = DW'(bus.iDATA);
    end
  end

  always_comb begin
    state_d     = state_q;
    load_second = 1'b0;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SETUP;
      S_SETUP: if (cnt_q == SETUP_LAST) state_d = S_EN_HI;
      S_EN_HI: if (cnt_q == EN_LAST) state_d = S_HOLD;
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          if (more_nibble) begin
            state_d     = S_SETUP;
            load_second = 1'b1;
          end else if (wait_none) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT:  if (cnt_q == wait_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter restarts on every state entry (including the SETUP re-entry for the low
  // nibble) and is parked at zero in IDLE/DONE so it can never wrap.
  always_comb begin
    if ((state_d != state_q) || load_second || (state_q == S_IDLE) || (state_q == S_DONE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lo_q       <= '0;
      single_q   <= 1'b0;
      long_q     <= 1'b0;
      second_q   <= 1'b0;
      lcd_data_q <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lcd_en_q <= (state_d == S_EN_HI);
      if (accept) begin
        lo_q       <= bus.iDATA[3:0];
        single_q   <= (BUS_4BIT != 0) && bus.iSingle;
        long_q     <= is_long;
        second_q   <= 1'b0;
        lcd_rs_q   <= bus.iRS;
        lcd_data_q <= first_part;
      end else if (load_second) begin
        second_q   <= 1'b1;
        lcd_data_q <= second_part;
      end
    end
  end

  assign bus.oReady    = (state_q == S_IDLE);
  assign bus.oBusy     = (state_q != S_IDLE);
  assign bus.oDone     = (state_q == S_DONE);
  assign bus.LCD_DATA  = lcd_data_q;
  assign bus.LCD_RS    = lcd_rs_q;
  assign bus.LCD_EN    = lcd_en_q;
  assign bus.LCD_RW    = 1'b0;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine: one 8-bit and one 4-bit instance with short timing
// (SETUP=2, EN=3, HOLD=1, CMD_WAIT=4, LONG_WAIT=10) and a strobe scoreboard per instance.
module tb_lcd_write_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [8:0] exp8_q[$];
  logic [4:0] exp4_q[$];

  lcd_write_engine_if #(.DW(8)) bus8();
  lcd_write_engine_if #(.DW(4)) bus4();

  lcd_write_engine #(
    .BUS_4BIT(0), .SETUP_CYC(2), .EN_HIGH_CYC(3), .HOLD_CYC(1),
    .CMD_WAIT_CYC(4), .LONG_WAIT_CYC(10), .CNT_W(8)
  ) dut8 (.iCLK(clk), .reset(reset), .bus(bus8.slave));

  lcd_write_engine #(
    .BUS_4BIT(1), .SETUP_CYC(2), .EN_HIGH_CYC(3), .HOLD_CYC(1),
    .CMD_WAIT_CYC(4), .LONG_WAIT_CYC(10), .CNT_W(8)
  ) dut4 (.iCLK(clk), .reset(reset), .bus(bus4.slave));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic f_ready(input bit sel);
    return sel ? bus4.oReady : bus8.oReady;
  endfunction

  function automatic logic f_done(input bit sel);
    return sel ? bus4.oDone : bus8.oDone;
  endfunction

  function automatic logic f_en(input bit sel);
    return sel ? bus4.LCD_EN : bus8.LCD_EN;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit sel, input logic v, input logic rs, input logic [7:0] d,
                        input logic s);
    if (sel) begin
      bus4.iValid = v; bus4.iRS = rs; bus4.iDATA = d; bus4.iSingle = s;
    end else begin
      bus8.iValid = v; bus8.iRS = rs; bus8.iDATA = d; bus8.iSingle = s;
    end
  endtask

  task automatic do_write(input bit sel, input logic rs, input logic [7:0] d, input logic s,
                          input int exp_done, input string tag);
    int n;
    int done_n;
    int first_en;
    if (!sel) begin
      exp8_q.push_back({rs, d});
    end else begin
      exp4_q.push_back({rs, d[7:4]});
      if (!s) exp4_q.push_back({rs, d[3:0]});
    end
    @(negedge clk);
    set_in(sel, 1'b1, rs, d, s);
    n = 0;
    while (!f_ready(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_before"}, f_ready(sel), 1'b1);
    @(posedge clk);
    #1 set_in(sel, 1'b0, rs, d, s);
    done_n   = 0;
    first_en = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (sel) chk({tag, "_c1_data"}, {bus4.LCD_RS, bus4.LCD_DATA}, {rs, d[7:4]});
        else     chk({tag, "_c1_data"}, {bus8.LCD_RS, bus8.LCD_DATA}, {rs, d});
      end
      if (f_en(sel) && first_en == 0) first_en = c;
      if (f_done(sel)) begin
        done_n = c;
        chk({tag, "_ready_in_done"}, f_ready(sel), 1'b0);
        break;
      end
    end
    chk({tag, "_first_en"}, first_en, 3);
    chk({tag, "_done_cycle"}, done_n, exp_done);
    @(negedge clk);
    chk({tag, "_ready_after"}, f_ready(sel), 1'b1);
  endtask

  // ---------------- scoreboard monitors ----------------
  logic en8_prev = 1'b0, en4_prev = 1'b0;
  int   run8 = 0, run4 = 0;

  always @(negedge clk) begin
    if (reset) begin
      en8_prev = 1'b0; run8 = 0;
    end else begin
      if (bus8.LCD_EN && !en8_prev) begin
        if (exp8_q.size() == 0) chk("strobe8_unexpected", bus8.LCD_EN, 1'b0);
        else chk("strobe8", {bus8.LCD_RS, bus8.LCD_DATA}, exp8_q.pop_front());
      end
      if (bus8.LCD_EN) run8++;
      else if (en8_prev) begin
        chk("en8_width", run8, 3);
        run8 = 0;
      end
      en8_prev = bus8.LCD_EN;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      en4_prev = 1'b0; run4 = 0;
    end else begin
      if (bus4.LCD_EN && !en4_prev) begin
        if (exp4_q.size() == 0) chk("strobe4_unexpected", bus4.LCD_EN, 1'b0);
        else chk("strobe4", {bus4.LCD_RS, bus4.LCD_DATA}, exp4_q.pop_front());
      end
      if (bus4.LCD_EN) run4++;
      else if (en4_prev) begin
        chk("en4_width", run4, 3);
        run4 = 0;
      end
      en4_prev = bus4.LCD_EN;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int acc_prev;
    int accepted;
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst8_ready", bus8.oReady, 1'b1);
    chk("rst8_busy",  bus8.oBusy,  1'b0);
    chk("rst8_done",  bus8.oDone,  1'b0);
    chk("rst8_pins",  {bus8.LCD_EN, bus8.LCD_RS, bus8.LCD_RW, bus8.LCD_DATA}, 11'h000);
    chk("rst4_ready", bus4.oReady, 1'b1);
    chk("rst4_pins",  {bus4.LCD_EN, bus4.LCD_RS, bus4.LCD_RW, bus4.LCD_DATA}, 7'h00);

    // 8-bit: data write, clear/home long waits, neighbouring normal commands
    do_write(1'b0, 1'b1, 8'h41, 1'b0, 11, "b8_data41");
    do_write(1'b0, 1'b0, 8'h01, 1'b0, 17, "b8_clear");
    do_write(1'b0, 1'b0, 8'h38, 1'b0, 11, "b8_func38");
    do_write(1'b0, 1'b0, 8'h02, 1'b0, 17, "b8_home02");
    do_write(1'b0, 1'b0, 8'h03, 1'b0, 17, "b8_home03");
    do_write(1'b0, 1'b0, 8'h04, 1'b0, 11, "b8_cmd04");
    do_write(1'b0, 1'b0, 8'h00, 1'b0, 11, "b8_cmd00");
    do_write(1'b0, 1'b1, 8'h01, 1'b0, 11, "b8_data01");
    do_write(1'b0, 1'b1, 8'hC3, 1'b1, 11, "b8_single_ignored");

    // 4-bit: two-nibble data, single-nibble init, two-nibble clear, single-nibble home
    do_write(1'b1, 1'b1, 8'hA5, 1'b0, 17, "b4_dataA5");
    do_write(1'b1, 1'b0, 8'h30, 1'b1, 11, "b4_single30");
    do_write(1'b1, 1'b0, 8'h01, 1'b0, 23, "b4_clear");
    do_write(1'b1, 1'b0, 8'h02, 1'b1, 17, "b4_single_home");

    // held iValid with changing data: only the byte present on the ready edge is taken
    @(negedge clk);
    bus8.iRS = 1'b1; bus8.iSingle = 1'b0; bus8.iValid = 1'b1;
    acc_prev = -1; accepted = 0; n = 0;
    while (accepted < 3 && n < 200) begin
      bus8.iDATA = 8'($urandom_range(0, 255));
      if (bus8.oDone) begin
        chk("stream_ready_in_done", bus8.oReady, 1'b0);
        chk("stream_done_lat", cyc - acc_prev, 11);
      end
      if (bus8.oReady) begin
        if (acc_prev >= 0) chk("stream_gap", cyc - acc_prev, 12);
        acc_prev = cyc;
        exp8_q.push_back({1'b1, bus8.iDATA});
        accepted++;
      end
      @(negedge clk);
      n++;
    end
    bus8.iValid = 1'b0;
    chk("stream_accepted", accepted, 3);
    n = 0;
    while (!bus8.oDone && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stream_last_done_lat", cyc - acc_prev, 11);
    @(negedge clk);

    // reset in the middle of an enable strobe
    exp8_q.push_back({1'b1, 8'h55});
    bus8.iDATA = 8'h55; bus8.iRS = 1'b1; bus8.iValid = 1'b1;
    n = 0;
    while (!bus8.oReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus8.iValid = 1'b0;
    n = 0;
    while (!bus8.LCD_EN && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_en_reached", bus8.LCD_EN, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_en",   bus8.LCD_EN,   1'b0);
    chk("rst_mid_data", bus8.LCD_DATA, 8'h00);
    chk("rst_mid_rs",   bus8.LCD_RS,   1'b0);
    chk("rst_mid_done", bus8.oDone,    1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_ready_after", bus8.oReady, 1'b1);
    exp8_q.delete();
    exp4_q.delete();
    do_write(1'b0, 1'b1, 8'h7E, 1'b0, 11, "b8_after_reset");

    repeat (3) @(negedge clk);
    chk("exp8_drained", exp8_q.size(), 0);
    chk("exp4_drained", exp4_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    checks++;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lcd_write_engine.md
Name: lcd_write_engine

Overview:
- Parametrised HD44780-class LCD write engine; successor to the single-shot 8-bit LCD write controller.
- Accepts one byte per valid/ready handshake and drives the LCD bus in 8-bit or 4-bit (two-nibble) mode.
- Timing is programmable: setup, enable-high, hold, and post-write busy wait, with an automatic long wait after clear/home commands.
- Sits between the display sequencer/text FSM and the LCD pins.

Parameters:
- BUS_4BIT, 0: 0 = 8-bit bus; 1 = 4-bit bus. In 4-bit mode, LCD_DATA[3:0] maps to panel D7..D4.
- SETUP_CYC, 2: cycles RS/data are stable before LCD_EN rises. Minimum 1.
- EN_HIGH_CYC, 12: cycles LCD_EN is high per strobe. Minimum 1.
- HOLD_CYC, 2: cycles RS/data are held after LCD_EN falls. Minimum 1.
- CMD_WAIT_CYC, 2000: busy wait after a normal write. 0 means no wait.
- LONG_WAIT_CYC, 80000: busy wait after clear/home. Must be ≥ CMD_WAIT_CYC.
- CNT_W, 17: timing counter width. Must hold the largest parameter value.

Ports:
- iCLK, in, 1: system clock.
- reset, in, 1: asynchronous active-high reset.
- iDATA, in, 8: byte to write.
- iRS, in, 1: 0 = command, 1 = data.
- iSingle, in, 1: 4-bit mode only; send high nibble only (init sequence). Ignored when BUS_4BIT = 0.
- iValid, in, 1: request valid.
- oReady, out, 1: engine idle; high exactly in IDLE.
- oDone, out, 1: one-cycle pulse at end of each transaction.
- oBusy, out, 1: equals ~oReady.
- LCD_DATA, out, BUS_4BIT ? 4 : 8: panel data bus.
- LCD_RW, out, 1: constant 0 (write-only).
- LCD_EN, out, 1: enable strobe, registered.
- LCD_RS, out, 1: register select, registered.

Behaviour:
- Reset (async, immediate): state IDLE, LCD_EN = 0, LCD_DATA = 0, LCD_RS = 0, oDone = 0, counter = 0, nibble flag = 0. Reset during a strobe drops LCD_EN in the same instant. No partial transaction resumes.
- Handshake: a transfer occurs on a clock edge where iValid && oReady. iDATA, iRS and iSingle are latched at that edge. iValid while busy is ignored (not queued). The requester holds iValid until it sees oReady.
- States and dwell times:
  - IDLE: wait for handshake.
  - SETUP: SETUP_CYC cycles. LCD_RS and LCD_DATA are driven from the latch in the first SETUP cycle.
  - EN_HI: EN_HIGH_CYC cycles with LCD_EN = 1.
  - HOLD: HOLD_CYC cycles with LCD_EN = 0 and data unchanged.
  - WAIT: selected wait-count cycles. Skipped if the count is 0.
  - DONE: 1 cycle, oDone = 1, then IDLE.
- 8-bit sequence: IDLE → SETUP → EN_HI → HOLD → WAIT → DONE.
- 4-bit sequence:
  - First strobe puts iDATA[7:4] on LCD_DATA.
  - After HOLD, if iSingle = 0, return to SETUP with iDATA[3:0] and strobe again.
  - If iSingle = 1, go to WAIT after the first HOLD.
  - No busy wait between the two nibbles.
- Wait selection: LONG_WAIT_CYC if latched iRS = 0 and iDATA[7:2] = 0 and iDATA[1:0] ≠ 0 (clear 0x01, home 0x02/0x03). Otherwise CMD_WAIT_CYC.
- Latency, 8-bit: handshake at edge 0 → LCD_EN high during cycles 1+SETUP_CYC through SETUP_CYC+EN_HIGH_CYC → oDone at cycle SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+wait+1 → oReady the next cycle.
- 4-bit two-nibble: adds SETUP_CYC+EN_HIGH_CYC+HOLD_CYC cycles.
- LCD_DATA and LCD_RS hold their last values in WAIT, DONE and IDLE until the next handshake.
- No back-to-back acceptance in the DONE cycle: oReady = 0 in DONE.
- The counter never wraps. Each state reloads the counter on entry; the exit compare is counter == dwell-1.

Test Plan:
1. BUS_4BIT=0, SETUP=2, EN=3, HOLD=1, CMD_WAIT=4; send iRS=1, iDATA=0x41 at edge 0 → LCD_DATA=0x41 and RS=1 from cycle 1; LCD_EN high cycles 3-5; oDone cycle 11; oReady cycle 12.
2. Same config, LONG_WAIT=10; command 0x01 → oDone at cycle 17. Command 0x38 → CMD_WAIT used, oDone at cycle 11.
3. BUS_4BIT=1, same timing; data 0xA5 → LCD_DATA=0xA during the first strobe and 0x5 during the second; two EN pulses of 3 cycles each, 3 cycles apart (HOLD+SETUP); oDone cycle 17.
4. BUS_4BIT=1, iSingle=1, command 0x30 → exactly one EN pulse with LCD_DATA=0x3; oDone cycle 11.
5. iValid held continuously with changing iDATA → only the byte present at the oReady edge is taken; oReady is low in the oDone cycle; the next transfer starts the following cycle.
6. Assert reset while LCD_EN = 1 → LCD_EN, LCD_DATA, LCD_RS and oDone read 0 before the next clock edge; oReady = 1 after release; a fresh write completes normally.
